// File: rtl/vga_clut_arb_if.sv
// Request/response and RAM pin bundle for the CLUT arbiter.
// slave  = the arbiter itself, master = requesters plus CLUT RAM.
interface vga_clut_arb_if #(
  parameter int AW = 9,
  parameter int DW = 24
);
  logic          ctrl_ven;
  logic          pix_req;
  logic [AW-1:0] pix_adr;
  logic          pix_ack;
  logic [DW-1:0] pix_q;
  logic          host_cyc;
  logic          host_stb;
  logic          host_we;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_di;
  logic          host_ack;
  logic [DW-1:0] host_do;
  logic [AW-1:0] ram_adr;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  modport slave (
    input  ctrl_ven, pix_req, pix_adr, host_cyc, host_stb, host_we,
           host_adr, host_di, ram_do,
    output pix_ack, pix_q, host_ack, host_do, ram_adr, ram_we, ram_di
  );

  modport master (
    output ctrl_ven, pix_req, pix_adr, host_cyc, host_stb, host_we,
           host_adr, host_di, ram_do,
    input  pix_ack, pix_q, host_ack, host_do, ram_adr, ram_we, ram_di
  );
endinterface

// File: rtl/vga_clut_arb.sv
// CLUT RAM arbiter: pixel lookups take priority, a bounded pixel run
// guarantees that a waiting host access is eventually served.
//
// state | meaning
// IDLE  | arbitrate, register RAM address/write on a grant
// ACC   | RAM samples address/write at the end of this cycle
// RESP  | RAM read data valid, capture it and raise the owner's ack
// ACK   | ack visible for this one cycle; turnaround hides stale requests
module vga_clut_arb #(
  parameter int AW          = 9,
  parameter int DW          = 24,
  parameter int MAX_PIX_RUN = 4
) (
  input logic            clk,
  input logic            nrst,
  vga_clut_arb_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ACC  = 4'b0010,
    RESP = 4'b0100,
    ACK  = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIX  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_PIX_RUN);

  state_t     state;
  owner_t     owner;
  logic [3:0] run;
  logic       host_wr;

  logic pr;
  logic hr;
  logic pix_win;

  // Request qualification and priority decision for the IDLE cycle.
  always_comb begin
    pr      = bus.pix_req & bus.ctrl_ven;
    hr      = bus.host_cyc & bus.host_stb;
    pix_win = pr & (~hr | (run < RUN_MAX));
  end

  // Sequencer: grant, RAM access, response capture and ack turnaround.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      run          <= 4'd0;
      host_wr      <= 1'b0;
      bus.pix_ack  <= 1'b0;
      bus.host_ack <= 1'b0;
      bus.pix_q    <= '0;
      bus.host_do  <= '0;
      bus.ram_adr  <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_di   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ram_we <= 1'b0;
          if (pix_win) begin
            bus.ram_adr <= AW'(bus.pix_adr);
            owner       <= OWN_PIX;
            // A pixel grant only counts toward the run while the host waits.
            run         <= hr ? run + 4'd1 : 4'd0;
            state       <= ACC;
          end else if (hr) begin
            bus.ram_adr <= AW'(bus.host_adr);
            owner       <= OWN_HOST;
            host_wr     <= bus.host_we;
            run         <= 4'd0;
            if (bus.host_we) begin
              bus.ram_di <= DW'(bus.host_di);
              bus.ram_we <= 1'b1;
            end
            state <= ACC;
          end else begin
            run <= 4'd0;
          end
        end
        ACC: begin
          bus.ram_we <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          // A requester that withdrew during the access gets no ack.
          if (owner == OWN_PIX) begin
            if (bus.ctrl_ven) begin
              bus.pix_q   <= DW'(bus.ram_do);
              bus.pix_ack <= 1'b1;
            end
          end else if (owner == OWN_HOST) begin
            if (bus.host_cyc) begin
              if (!host_wr) bus.host_do <= DW'(bus.ram_do);
              bus.host_ack <= 1'b1;
            end
          end
          state <= ACK;
        end
        ACK: begin
          bus.pix_ack  <= 1'b0;
          bus.host_ack <= 1'b0;
          owner        <= OWN_NONE;
          state        <= IDLE;
        end
        default: begin
          bus.pix_ack  <= 1'b0;
          bus.host_ack <= 1'b0;
          bus.ram_we   <= 1'b0;
          owner        <= OWN_NONE;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_clut_arb.md
Name: vga_clut_arb

Overview:
Arbiter and sequencer for the single-port colour lookup table (CLUT) RAM. It shares the RAM between two requesters. The pixel side is the colour processor's 8bpp pseudo-colour lookup (req/offset/ack, read-only). The host side is the Wishbone slave register/CLUT window (read/write). The pixel side has real-time priority, and a bounded-run rule guarantees host progress. The block owns all RAM address, write-enable and data pins and returns registered read data to the winning requester.

Parameters:
AW, 9, CLUT address width (bank bit + 8-bit offset; 512 entries)
DW, 24, CLUT entry width ({R,G,B})
MAX_PIX_RUN, 4, max consecutive pixel grants while a host request waits (1..15)

Ports:
clk  in  1  master clock
nrst  in  1  asynchronous active-low reset
ctrl_ven  in  1  video enable; low = pixel requests ignored
pix_req  in  1  pixel lookup request, level, held until pix_ack
pix_adr  in  AW  pixel lookup address, stable while pix_req high
pix_ack  out  1  one-cycle pulse: pix_q valid
pix_q  out  DW  pixel lookup data, held until next pixel ack
host_cyc  in  1  host cycle
host_stb  in  1  host strobe; request = host_cyc & host_stb
host_we  in  1  host write enable
host_adr  in  AW  host address
host_di  in  DW  host write data
host_ack  out  1  one-cycle pulse: host access complete
host_do  out  DW  host read data, valid with host_ack, held afterwards
ram_adr  out  AW  RAM address (registered)
ram_we  out  1  RAM write enable (registered)
ram_di  out  DW  RAM write data (registered)
ram_do  in  DW  RAM read data, synchronous, 1-cycle latency

Behaviour:
- Reset (nrst low, async): state IDLE; pix_ack=0, host_ack=0, ram_we=0, ram_adr=0, ram_di=0, pix_q=0, host_do=0, run counter=0, owner=none. Reset mid-access abandons the access with no ack. A write in flight may or may not have reached the RAM.
- State machine, one-hot: IDLE, ACC, RESP, ACK.
- IDLE: evaluate pr = pix_req & ctrl_ven and hr = host_cyc & host_stb.
  - Grant pixel if pr & (!hr | run < MAX_PIX_RUN).
  - Otherwise grant host if hr.
  - On grant: register ram_adr (pix_adr or host_adr), owner, and for a host write ram_di=host_di, ram_we=1. Go to ACC.
  - No request: stay in IDLE with ram_we=0.
- ACC: RAM samples address/write at the end of this cycle. Clear ram_we at the edge. Go to RESP.
- RESP: ram_do valid.
  - Pixel owner: pix_q<=ram_do and pix_ack<=1, unless ctrl_ven is now low (ack suppressed, pix_q unchanged).
  - Host owner: host_do<=ram_do on a read (unchanged on a write), host_ack<=1, unless host_cyc is now low (ack suppressed, write already committed).
  - Go to ACK.
- ACK: ack high for exactly this cycle, cleared at the edge. Go to IDLE. This turnaround prevents a requester's stale req (deasserted one cycle after ack) from causing a duplicate grant.
- Latency: request seen in IDLE at cycle n gives ack high in cycle n+3. One access per 4 cycles maximum.
- Run counter (4 bits, saturating at MAX_PIX_RUN):
  - Increments on a pixel grant while hr=1.
  - Clears on a host grant.
  - Clears in IDLE when hr=0.
- Simultaneous requests with run < MAX_PIX_RUN: pixel wins. With run == MAX_PIX_RUN: host wins.
- pix_ack and host_ack are never high in the same cycle; at most one ack per grant.
- ctrl_ven low: pixel requests are never granted. Host service is unaffected.
- Address width: pix_adr/host_adr are passed unmodified; no wrap logic.

Test Plan:
- Host write then read: write adr 9'h005 data 24'h12_34_56, then read adr 9'h005 -> host_ack 3 cycles after each request; host_do=24'h123456; ram_we high for exactly one cycle.
- Pixel lookup: preload adr 9'h0A0=24'hFF8000, pix_req with pix_adr=9'h0A0 -> pix_ack pulse 3 cycles later, pix_q=24'hFF8000, no second ack while req drops.
- Starvation bound: pix_req held high continuously with changing addresses, host read pending, MAX_PIX_RUN=4 -> exactly 4 pix_acks, then one host_ack, then pixel service resumes.
- Simultaneous first request, run=0 -> pixel granted first; host ack follows 4 cycles after pix_ack.
- ctrl_ven dropped during ACC of a pixel access -> no pix_ack, pix_q unchanged; a following host read completes normally.
- nrst asserted in RESP of a host read -> all outputs 0 immediately; after release, new host request completes with normal 3-cycle latency.
